// File: rtl/rpc_chan_pipe.sv
// rpc_chan_pipe: NumChan independent valid/ready FIFO channels between the pin-level bus and the rpc core.
// Defining RPC_PIPE_WDOG_EN adds a sticky per-channel stall watchdog; otherwise wdog_o is tied low.
module rpc_chan_pipe #(
    parameter int unsigned NumChan    = 5,
    parameter int unsigned DataWidth  = 128,
    parameter int unsigned Depth      = 2,
    parameter int unsigned WdogCycles = 1024,
    localparam int unsigned OccW      = (Depth < 1) ? 1 : $clog2(Depth + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NumChan-1:0]           in_valid_i,
    output logic [NumChan-1:0]           in_ready_o,
    input  logic [NumChan*DataWidth-1:0] in_data_i,
    output logic [NumChan-1:0]           out_valid_o,
    input  logic [NumChan-1:0]           out_ready_i,
    output logic [NumChan*DataWidth-1:0] out_data_o,
    output logic [NumChan*OccW-1:0]      occ_o,
    input  logic                         wdog_clr_i,
    output logic [NumChan-1:0]           wdog_o
);

    if (Depth == 0) begin : g_bypass
        logic unused_bypass;

        assign in_ready_o    = out_ready_i;
        assign out_valid_o   = in_valid_i;
        assign out_data_o    = in_data_i;
        assign occ_o         = '0;
        assign unused_bypass = ^{flush_i, clk_i, rst_i};
    end else begin : g_fifo
        localparam int unsigned     PtrW    = (Depth < 2) ? 1 : $clog2(Depth);
        localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
        localparam logic [OccW-1:0] Full    = OccW'(Depth);

        typedef logic [DataWidth-1:0] data_t;

        logic               init_q, init_d;
        logic [PtrW-1:0]    wr_ptr_q [NumChan];
        logic [PtrW-1:0]    wr_ptr_d [NumChan];
        logic [PtrW-1:0]    rd_ptr_q [NumChan];
        logic [PtrW-1:0]    rd_ptr_d [NumChan];
        logic [OccW-1:0]    cnt_q    [NumChan];
        logic [OccW-1:0]    cnt_d    [NumChan];
        data_t              mem_q    [NumChan][Depth];
        data_t              mem_d    [NumChan][Depth];
        logic [NumChan-1:0] push, pop;

        function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
            return (p == LastPtr) ? '0 : p + PtrW'(1);
        endfunction

        always_comb begin
            init_d      = 1'b1;
            mem_d       = mem_q;
            push        = '0;
            pop         = '0;
            in_ready_o  = '0;
            out_valid_o = '0;
            out_data_o  = '0;
            occ_o       = '0;
            for (int unsigned c = 0; c < NumChan; c++) begin
                wr_ptr_d[c] = wr_ptr_q[c];
                rd_ptr_d[c] = rd_ptr_q[c];
                // Ready comes only from local count: a full buffer refuses even when popping.
                in_ready_o[c]  = init_q && (cnt_q[c] != Full) && !flush_i;
                out_valid_o[c] = (cnt_q[c] != '0);
                push[c]        = in_valid_i[c] & in_ready_o[c];
                pop[c]         = out_valid_o[c] & out_ready_i[c];
                out_data_o[c*DataWidth +: DataWidth] = mem_q[c][rd_ptr_q[c]];
                occ_o[c*OccW +: OccW]                = cnt_q[c];
                if (push[c]) begin
                    mem_d[c][wr_ptr_q[c]] = in_data_i[c*DataWidth +: DataWidth];
                    wr_ptr_d[c]           = ptr_next(wr_ptr_q[c]);
                end
                if (pop[c]) begin
                    rd_ptr_d[c] = ptr_next(rd_ptr_q[c]);
                end
                cnt_d[c] = cnt_q[c] + OccW'(push[c]) - OccW'(pop[c]);
                if (flush_i) begin
                    wr_ptr_d[c] = '0;
                    rd_ptr_d[c] = '0;
                    cnt_d[c]    = '0;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                init_q <= 1'b0;
                for (int unsigned c = 0; c < NumChan; c++) begin
                    wr_ptr_q[c] <= '0;
                    rd_ptr_q[c] <= '0;
                    cnt_q[c]    <= '0;
                    for (int unsigned d = 0; d < Depth; d++) begin
                        mem_q[c][d] <= '0;
                    end
                end
            end else begin
                init_q   <= init_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                mem_q    <= mem_d;
            end
        end
    end

`ifdef RPC_PIPE_WDOG_EN
    localparam int unsigned    WdW     = $clog2(WdogCycles + 1);
    localparam logic [WdW-1:0] WdMax   = WdW'(WdogCycles);
    localparam bit             FlushEn = (Depth != 0);

    logic [WdW-1:0]     wd_cnt_q [NumChan];
    logic [WdW-1:0]     wd_cnt_d [NumChan];
    logic [NumChan-1:0] wd_flag_q, wd_flag_d;

    always_comb begin
        wd_flag_d = '0;
        for (int unsigned c = 0; c < NumChan; c++) begin
            if (!(out_valid_o[c] && !out_ready_i[c]) || (FlushEn && flush_i)) begin
                wd_cnt_d[c] = '0;
            end else if (wd_cnt_q[c] != WdMax) begin
                wd_cnt_d[c] = wd_cnt_q[c] + WdW'(1);
            end else begin
                wd_cnt_d[c] = wd_cnt_q[c];
            end
            // Set fires on reaching the limit, so a clear sticks while the counter sits saturated.
            wd_flag_d[c] = ((wd_cnt_d[c] == WdMax) && (wd_cnt_q[c] != WdMax))
                         || (wd_flag_q[c] && !wdog_clr_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_flag_q <= '0;
            for (int unsigned c = 0; c < NumChan; c++) begin
                wd_cnt_q[c] <= '0;
            end
        end else begin
            wd_flag_q <= wd_flag_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    assign wdog_o = wd_flag_q;
`else
    logic unused_wdog_clr;

    assign unused_wdog_clr = wdog_clr_i;
    assign wdog_o          = '0;
`endif

endmodule

// File: tb/tb_rpc_chan_pipe.sv
// Scoreboard bench for rpc_chan_pipe: Depth 1/2/3 instances checked against a queue model every cycle,
// plus a Depth=0 bypass instance checked combinationally.
module tb_rpc_chan_pipe;

    localparam int NC = 5;
    localparam int DW = 16;
    localparam int WD = 16;

    logic clk = 1'b0;
    logic rst;
    logic wclr;

    // index k: 0 -> Depth 1, 1 -> Depth 2, 2 -> Depth 3
    logic [NC-1:0]    iv   [3];
    logic [NC-1:0]    ir   [3];
    logic [NC-1:0]    ov   [3];
    logic [NC-1:0]    orr  [3];
    logic [NC*DW-1:0] idat [3];
    logic [NC*DW-1:0] odat [3];
    logic             fl   [3];
    logic [NC-1:0]    wd   [3];
    logic [NC-1:0]    occ1;
    logic [2*NC-1:0]  occ2, occ3;

    logic [NC-1:0]    iv0, ir0, ov0, or0, occ0, wd0;
    logic [NC*DW-1:0] id0, od0;
    logic             fl0;

    logic [DW-1:0] q [3][NC][$];
    int            pops  [3][NC];
    int            wcnt  [3][NC];
    bit            wflag [3][NC];
    bit            init_m;
    int            checks;
    int            errors;
    int            base;

    always #5 clk = ~clk;

    rpc_chan_pipe #(.NumChan(NC), .DataWidth(DW), .Depth(1), .WdogCycles(WD)) u_d1 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[0]), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .in_data_i(idat[0]), .out_valid_o(ov[0]), .out_ready_i(orr[0]), .out_data_o(odat[0]),
        .occ_o(occ1), .wdog_clr_i(wclr), .wdog_o(wd[0]));

    rpc_chan_pipe #(.NumChan(NC), .DataWidth(DW), .Depth(2), .WdogCycles(WD)) u_d2 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[1]), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .in_data_i(idat[1]), .out_valid_o(ov[1]), .out_ready_i(orr[1]), .out_data_o(odat[1]),
        .occ_o(occ2), .wdog_clr_i(wclr), .wdog_o(wd[1]));

    rpc_chan_pipe #(.NumChan(NC), .DataWidth(DW), .Depth(3), .WdogCycles(WD)) u_d3 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[2]), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
        .in_data_i(idat[2]), .out_valid_o(ov[2]), .out_ready_i(orr[2]), .out_data_o(odat[2]),
        .occ_o(occ3), .wdog_clr_i(wclr), .wdog_o(wd[2]));

    rpc_chan_pipe #(.NumChan(NC), .DataWidth(DW), .Depth(0), .WdogCycles(WD)) u_d0 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl0), .in_valid_i(iv0), .in_ready_o(ir0),
        .in_data_i(id0), .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0),
        .occ_o(occ0), .wdog_clr_i(wclr), .wdog_o(wd0));

    task automatic chk(input string tag, input int k, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d ch=%0d observed=%0h expected=%0h", tag, k, c, obs, exp);
        end
    endtask

    function automatic logic [31:0] occ_of(input int k, input int c);
        case (k)
            0:       return 32'(occ1[c]);
            1:       return 32'(occ2[c*2 +: 2]);
            default: return 32'(occ3[c*2 +: 2]);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_in_ready"}, k, -1, 32'(ir[k]), 32'd0);
            chk({tag, "_out_valid"}, k, -1, 32'(ov[k]), 32'd0);
            chk({tag, "_out_data"}, k, -1, 32'(|odat[k]), 32'd0);
            chk({tag, "_wdog"}, k, -1, 32'(wd[k]), 32'd0);
        end
        chk({tag, "_occ"}, 0, -1, 32'(occ1), 32'd0);
        chk({tag, "_occ"}, 1, -1, 32'(occ2), 32'd0);
        chk({tag, "_occ"}, 2, -1, 32'(occ3), 32'd0);
    endtask

    // Model: queue length is the occupancy; handshakes are decided from model state, not DUT outputs.
    always @(negedge clk) begin
        int n;
        bit er, push, pop, stall;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NC; c++) begin
                if (rst) begin
                    q[k][c].delete();
                    wcnt[k][c]  = 0;
                    wflag[k][c] = 1'b0;
                end else begin
                    n  = q[k][c].size();
                    er = init_m && (n < k + 1) && !fl[k];
                    chk("in_ready", k, c, 32'(ir[k][c]), 32'(er));
                    chk("out_valid", k, c, 32'(ov[k][c]), 32'(n != 0));
                    chk("occ", k, c, occ_of(k, c), 32'(n));
                    if (n != 0) chk("out_data", k, c, 32'(odat[k][c*DW +: DW]), 32'(q[k][c][0]));
`ifdef RPC_PIPE_WDOG_EN
                    chk("wdog", k, c, 32'(wd[k][c]), 32'(wflag[k][c]));
`else
                    chk("wdog", k, c, 32'(wd[k][c]), 32'd0);
`endif
                    pop   = (n != 0) && orr[k][c];
                    push  = iv[k][c] && er;
                    stall = (n != 0) && !orr[k][c];
                    if (pop) begin
                        void'(q[k][c].pop_front());
                        pops[k][c]++;
                    end
                    if (push) q[k][c].push_back(idat[k][c*DW +: DW]);
                    if (fl[k]) q[k][c].delete();
                    wflag[k][c] = (stall && !fl[k] && wcnt[k][c] == WD - 1) || (wflag[k][c] && !wclr);
                    wcnt[k][c]  = (stall && !fl[k]) ? ((wcnt[k][c] == WD) ? WD : wcnt[k][c] + 1) : 0;
                end
            end
        end
        init_m = !rst;
    end

    initial begin
        checks = 0;
        errors = 0;
        init_m = 1'b0;
        rst    = 1'b1;
        wclr   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; orr[k] = '0; idat[k] = '0; fl[k] = 1'b0;
            for (int c = 0; c < NC; c++) pops[k][c] = 0;
        end
        iv0 = '0; or0 = '0; id0 = '0; fl0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) chk("ready_first_cycle", k, -1, 32'(ir[k]), 32'd0);
        step();
        for (int k = 0; k < 3; k++) chk("ready_after_init", k, -1, 32'(ir[k]), 32'h1f);

        // 1: Depth=2 ch0 streams 8 beats at full rate
        orr[1] = '1;
        base = pops[1][0];
        for (int i = 1; i <= 8; i++) begin
            iv[1][0] = 1'b1;
            idat[1][15:0] = 16'(i);
            step();
        end
        iv[1][0] = 1'b0;
        step();
        chk("t1_beats_in_9_cycles", 1, 0, 32'(pops[1][0] - base), 32'd8);

        // 2: Depth=2 backpressure, 3rd beat waits for space
        orr[1] = '0;
        iv[1][0] = 1'b1; idat[1][15:0] = 16'hA1; step();
        idat[1][15:0] = 16'hA2; step();
        idat[1][15:0] = 16'hA3; step();
        chk("t2_full_ready", 1, 0, 32'(ir[1][0]), 32'd0);
        chk("t2_full_occ", 1, 0, 32'(occ2[1:0]), 32'd2);
        orr[1][0] = 1'b1;
        #1;
        chk("t2_ready_during_pop", 1, 0, 32'(ir[1][0]), 32'd0);
        step();
        orr[1][0] = 1'b0;
        chk("t2_ready_after_pop", 1, 0, 32'(ir[1][0]), 32'd1);
        step();
        iv[1][0] = 1'b0;
        chk("t2_occ_refilled", 1, 0, 32'(occ2[1:0]), 32'd2);
        orr[1] = '1;
        repeat (4) step();

        // 3: random traffic on all buffered instances, with flushes and a mid-stream reset
        for (int cyc = 0; cyc < 4400; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]   = 5'($urandom);
                orr[k]  = 5'($urandom);
                idat[k] = {16'($urandom), 32'($urandom), 32'($urandom)};
                fl[k]   = ($urandom_range(63) == 0);
            end
            wclr = ($urandom_range(31) == 0);
            if (cyc == 2000) begin
                #2 rst = 1'b1;
                #1 chk_reset_state("mid_reset");
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; orr[k] = '1; fl[k] = 1'b0;
        end
        wclr = 1'b1;
        repeat (5) step();
        wclr = 1'b0;
        step();
        chk("t3_drained_occ3", 2, -1, 32'(occ3), 32'd0);
        chk("t3_wdog_cleared", 1, -1, 32'(wd[1]), 32'd0);

        // 4: flush with occ=2 and out_ready=1
        orr[1] = '0;
        iv[1][0] = 1'b1; idat[1][15:0] = 16'hB1; step();
        idat[1][15:0] = 16'hB2; step();
        chk("t4_occ_before", 1, 0, 32'(occ2[1:0]), 32'd2);
        fl[1] = 1'b1; orr[1] = '1; idat[1][15:0] = 16'hB3;
        base = pops[1][0];
        #1;
        chk("t4_ready_in_flush", 1, 0, 32'(ir[1][0]), 32'd0);
        step();
        fl[1] = 1'b0; iv[1][0] = 1'b0;
        chk("t4_occ_after", 1, -1, 32'(occ2), 32'd0);
        chk("t4_valid_after", 1, -1, 32'(ov[1]), 32'd0);
        chk("t4_head_delivered", 1, 0, 32'(pops[1][0] - base), 32'd1);

        // 5: watchdog on ch2 of Depth=2
        orr[1] = 5'b11011;
        iv[1][2] = 1'b1; idat[1][47:32] = 16'hC1; step();
        idat[1][47:32] = 16'hC2; step();
        iv[1][2] = 1'b0;
        repeat (20) step();
`ifdef RPC_PIPE_WDOG_EN
        chk("t5_wdog_set", 1, 2, 32'(wd[1]), 32'h04);
`else
        chk("t5_wdog_off", 1, 2, 32'(wd[1]), 32'h00);
`endif
        wclr = 1'b1; step(); wclr = 1'b0;
        chk("t5_wdog_clr", 1, 2, 32'(wd[1]), 32'h00);
        orr[1][2] = 1'b1; step(); orr[1][2] = 1'b0;
        repeat (10) step();
        chk("t5_counter_restart", 1, 2, 32'(wd[1]), 32'h00);
        repeat (8) step();
`ifdef RPC_PIPE_WDOG_EN
        chk("t5_wdog_reset_after_pop", 1, 2, 32'(wd[1]), 32'h04);
`else
        chk("t5_wdog_off2", 1, 2, 32'(wd[1]), 32'h00);
`endif
        wclr = 1'b1; orr[1] = '1; step(); wclr = 1'b0;
        repeat (3) step();

        // 6: Depth=1 rate, then Depth=0 bypass
        orr[0] = '1; iv[0][0] = 1'b1;
        base = pops[0][0];
        for (int i = 0; i < 20; i++) begin
            idat[0][15:0] = 16'(i + 'h40);
            step();
        end
        iv[0][0] = 1'b0;
        chk("t6_depth1_rate", 0, 0, 32'(pops[0][0] - base), 32'd10);
        for (int i = 0; i < 8; i++) begin
            iv0 = 5'($urandom); or0 = 5'($urandom); fl0 = 1'($urandom);
            id0 = {16'($urandom), 32'($urandom), 32'($urandom)};
            #1;
            chk("byp_valid", -1, i, 32'(ov0), 32'(iv0));
            chk("byp_ready", -1, i, 32'(ir0), 32'(or0));
            chk("byp_data_lo", -1, i, od0[31:0], id0[31:0]);
            chk("byp_data_mid", -1, i, od0[63:32], id0[63:32]);
            chk("byp_data_hi", -1, i, 32'(od0[79:64]), 32'(id0[79:64]));
            chk("byp_occ", -1, i, 32'(occ0), 32'd0);
        end
        iv0 = '0;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
